calc_op_sequencer: RTL and testbench
====================================

CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock), then rst input 1 (asynchronous, active-low reset).
REQ-002 The block SHALL have these ports:
- start  input  1  operation request; sampled only while busy=0.
- op  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
- a  input  16  operand A, unsigned.
- b  input  16  operand B, unsigned.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- result  output  16  operation result, held until the next completion.
- ovf  output  1  carry / borrow / product-overflow flag, qualified by done.
- err  output  1  reserved-op flag, qualified by done.
REQ-003 The block SHALL have no parameters; data width is fixed at 16.

Function
REQ-004 The FSM SHALL have states IDLE, EXEC and FINISH.
- IDLE -> EXEC: on start=1 at edge N; a, b and op are latched at that edge.
- EXEC: ADD/SUB for 1 cycle; MUL for 16 cycles; reserved op for 1 cycle.
- EXEC -> FINISH: at the edge that completes the operation.
- FINISH -> IDLE: after 1 cycle. FINISH also accepts start, going straight to EXEC.
REQ-005 All operations SHALL share a single 16-bit adder instance computing X + (inv ? ~Y : Y) + cin, with a 17th carry bit.
REQ-006 ADD SHALL produce result = (a+b) mod 2^16 and ovf = carry-out.
REQ-007 SUB SHALL compute a + ~b + 1, giving result = (a-b) mod 2^16 and ovf = NOT carry-out (borrow).
REQ-008 MUL SHALL be unsigned shift-add over a 4-bit iteration counter 0..15.
- Each EXEC cycle: if the multiplier LSB is 1, the adder adds the multiplicand to the high accumulator; then {carry, high, low} shifts right by 1.
- After counter value 15: result = low 16 bits of a*b; ovf = 1 if any of the high 16 bits is nonzero.
REQ-009 Latency SHALL be fixed, independent of operand values (including zero operands). For start sampled at edge N:
- done and result update at edge N+1 for ADD/SUB/reserved.
- done and result update at edge N+16 for MUL.
REQ-010 done SHALL be registered and high for exactly one cycle (the FINISH state).
REQ-011 busy SHALL rise at edge N and fall at the edge where done rises.
REQ-012 start while busy=1 SHALL be ignored, with no effect on state or latched operands.
REQ-013 start in the cycle where done=1 SHALL be accepted (back-to-back); the next done then follows the REQ-009 latency.
REQ-014 Changes on a, b and op while busy=1 SHALL have no effect on the operation in progress.
REQ-015 A reserved op SHALL give result=0x0000, ovf=0, err=1 with done.
REQ-016 err SHALL be 0 on every non-reserved completion.
REQ-017 result, ovf and err SHALL hold their values between completions.

Reset
REQ-018 rst=0 SHALL asynchronously force: FSM IDLE, busy=0, done=0, result=0x0000, ovf=0, err=0, iteration counter=0, accumulators=0.
REQ-019 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-020 start sampled at the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-021 Shared package calc_seq_pkg SHALL hold:
- op encodings (OP_ADD, OP_SUB, OP_MUL, OP_RSVD);
- FSM state encoding;
- DATA_W=16 and MUL_ITERS=16.
REQ-022 The shared adder SHALL be one combinational sub-module, add16_shared, with ports x, y, inv, cin, sum[15:0] and cout.
REQ-023 calc_op_sequencer SHALL instantiate add16_shared exactly once and multiplex its inputs by state and op.

Verification
REQ-024 ADD a=0xFFFF, b=0x0001 -> at edge N+1: result=0x0000, ovf=1, done pulse of 1 cycle.
REQ-025 SUB 0x0007-0x0005 -> result 0x0002, ovf=0; SUB 0x0005-0x0007 -> result 0xFFFE, ovf=1.
REQ-026 MUL 0x00FF*0x0101 -> result 0xFFFF, ovf=0 at edge N+16; MUL 0x1000*0x0010 -> result 0x0000, ovf=1; MUL 0x0000*0xFFFF -> result 0x0000, ovf=0, still at edge N+16.
REQ-027 Back-to-back and ignored start:
- MUL start, then start pulses at edges N+3 and N+10 are ignored (busy=1), with a, b changed meanwhile; result still matches the original operands.
- ADD start in the done cycle -> its done at 1 cycle after acceptance.
REQ-028 rst=0 asserted at MUL iteration 8 -> all outputs 0 immediately, no done pulse; a new SUB 0x0010-0x0001 after reset -> result 0x000F.
REQ-029 op=11 -> at edge N+1: done=1, err=1, result=0x0000; the following ADD completion has err=0.

Source files
------------

// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the calculator op sequencer.
// Op encodings, FSM states and datapath widths.
package calc_seq_pkg;

  localparam int DATA_W    = 16;
  localparam int MUL_ITERS = 16;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  localparam logic [CNT_W-1:0] LAST_ITER =
    CNT_W'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EXEC   = 2'b01,
    FINISH = 2'b10
  } state_e;

  function automatic logic is_mul(input op_e o);
    return o == OP_MUL;
  endfunction

endpackage

// File: rtl/add16_shared.sv
// Shared 16-bit adder: x + (inv ? ~y : y) + cin.
// Carry-out is the 17th bit of the sum.
module add16_shared
  import calc_seq_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              inv,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] y_eff;
  logic [DATA_W:0]   full;

  // conditional inversion then a single wide add
  always_comb begin
    y_eff = inv ? ~y : y;
    full  = {1'b0, x}
          + {1'b0, y_eff}
          + {{DATA_W{1'b0}}, cin};
  end

  assign sum  = full[DATA_W-1:0];
  assign cout = full[DATA_W];

endmodule

// File: rtl/calc_op_sequencer.sv
// ADD/SUB/MUL sequencer around one shared adder.
// MUL is 16-cycle shift-add; other ops take one cycle.
module calc_op_sequencer
  import calc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              err
);

  state_e            state;
  state_e            state_nx;
  op_e               op_q;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              last;

  logic [DATA_W-1:0] add_x;
  logic [DATA_W-1:0] add_y;
  logic              add_inv;
  logic              add_cin;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;

  logic [DATA_W-1:0] hi_nx;
  logic [DATA_W-1:0] lo_nx;

  assign accept = start && (state != EXEC);
  assign last   = !is_mul(op_q) || (cnt == LAST_ITER);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = EXEC;
      EXEC:    if (last)  state_nx = FINISH;
      FINISH:  state_nx = start ? EXEC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // status outputs decoded from the state register
  always_comb begin
    busy = (state == EXEC);
    done = (state == FINISH);
  end

  // adder input mux: A op B, or hi + (lsb ? mcand : 0)
  always_comb begin
    add_x   = mcand;
    add_y   = lo;
    add_inv = 1'b0;
    add_cin = 1'b0;
    case (op_q)
      OP_SUB: begin
        add_inv = 1'b1;
        add_cin = 1'b1;
      end
      OP_MUL: begin
        add_x = hi;
        add_y = lo[0] ? mcand : '0;
      end
      default: ;
    endcase
  end

  add16_shared u_add (
    .x    (add_x),
    .y    (add_y),
    .inv  (add_inv),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // {carry, hi, lo} shifted right by one
  always_comb begin
    hi_nx = {add_cout, add_sum[DATA_W-1:1]};
    lo_nx = {add_sum[0], lo[DATA_W-1:1]};
  end

  // operand latch and multiply accumulators
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= OP_ADD;
      mcand <= '0;
      lo    <= '0;
      hi    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      op_q  <= op_e'(op);
      mcand <= a;
      lo    <= b;
      hi    <= '0;
      cnt   <= '0;
    end else if (state == EXEC && is_mul(op_q)) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt + 1'b1;
    end
  end

  // result/flags update only on the completing edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else if (state == EXEC && last) begin
      case (op_q)
        OP_ADD: begin
          result <= add_sum;
          ovf    <= add_cout;
          err    <= 1'b0;
        end
        OP_SUB: begin
          result <= add_sum;
          ovf    <= ~add_cout;
          err    <= 1'b0;
        end
        OP_MUL: begin
          result <= lo_nx;
          ovf    <= |hi_nx;
          err    <= 1'b0;
        end
        default: begin
          result <= '0;
          ovf    <= 1'b0;
          err    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer.
// Hand-computed vectors; one check task for all compares.
module tb_calc_op_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        err;

  int n_chk;
  int n_pass;

  calc_op_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(
    input string       tag,
    input logic [1:0]  o,
    input logic [15:0] x,
    input logic [15:0] y,
    input int          lat,
    input logic [15:0] er,
    input logic        eo,
    input logic        ee
  );
    logic early;
    early = 1'b0;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".busy_rise"}, 32'(busy), 32'd1);
    for (int i = 1; i < lat; i++) begin
      step();
      if (done || !busy) early = 1'b1;
    end
    check({tag, ".early"}, 32'(early), 32'd0);
    step();
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_fall"}, 32'(busy), 32'd0);
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    check({tag, ".err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    logic bad;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;

    repeat (3) step();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    rst = 1'b1;

    // first edge after reset release
    do_op("add_wrap", 2'b00, 16'hFFFF, 16'h0001,
          1, 16'h0000, 1'b1, 1'b0);
    step();
    check("add_wrap.pulse", 32'(done), 32'd0);
    check("add_wrap.hold_ovf", 32'(ovf), 32'd1);

    do_op("sub_pos", 2'b01, 16'h0007, 16'h0005,
          1, 16'h0002, 1'b0, 1'b0);
    step();
    do_op("sub_neg", 2'b01, 16'h0005, 16'h0007,
          1, 16'hFFFE, 1'b1, 1'b0);
    step();
    check("sub_neg.hold_res", 32'(result), 32'h0000FFFE);

    do_op("mul_ffff", 2'b10, 16'h00FF, 16'h0101,
          16, 16'hFFFF, 1'b0, 1'b0);
    step();
    do_op("mul_ovf", 2'b10, 16'h1000, 16'h0010,
          16, 16'h0000, 1'b1, 1'b0);
    step();
    do_op("mul_zero", 2'b10, 16'h0000, 16'hFFFF,
          16, 16'h0000, 1'b0, 1'b0);
    step();

    // MUL 3*5 with ignored starts and noisy operands
    op    = 2'b10;
    a     = 16'h0003;
    b     = 16'h0005;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    op    = 2'b00;
    bad   = 1'b0;
    for (int k = 1; k < 16; k++) begin
      start = (k == 3 || k == 10);
      step();
      if (done || !busy) bad = 1'b1;
    end
    start = 1'b0;
    check("ign.busy", 32'(bad), 32'd0);
    step();
    check("ign.done", 32'(done), 32'd1);
    check("ign.result", 32'(result), 32'h0000000F);
    check("ign.ovf", 32'(ovf), 32'd0);

    // back-to-back ADD in the done cycle
    op    = 2'b00;
    a     = 16'h1234;
    b     = 16'h1111;
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.done_low", 32'(done), 32'd0);
    step();
    check("b2b.done", 32'(done), 32'd1);
    check("b2b.result", 32'(result), 32'h00002345);
    step();

    do_op("rsvd", 2'b11, 16'h1234, 16'h5678,
          1, 16'h0000, 1'b0, 1'b1);
    step();
    check("rsvd.hold_err", 32'(err), 32'd1);
    do_op("add_after", 2'b00, 16'h0001, 16'h0002,
          1, 16'h0003, 1'b0, 1'b0);
    step();

    // reset at MUL iteration 8
    op    = 2'b10;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check("abort.busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.ovf", 32'(ovf), 32'd0);
    check("abort.err", 32'(err), 32'd0);
    bad = 1'b0;
    repeat (3) begin
      step();
      if (done) bad = 1'b1;
    end
    check("abort.no_done", 32'(bad), 32'd0);
    rst = 1'b1;
    do_op("sub_post", 2'b01, 16'h0010, 16'h0001,
          1, 16'h000F, 1'b0, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
